// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Provides the FSM state encoding and the default operand width.
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/FullAdder.sv
// One-bit full-adder cell.
// Ports:
//   i1, i2 : addend bits
//   cin    : carry in
//   s      : sum bit
//   c      : carry out
module FullAdder (
  input  logic i1,
  input  logic i2,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = i1 ^ i2 ^ cin;
  assign c = (i1 & i2) | (cin & (i1 ^ i2));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start
// and fed LSB-first, one bit per clock, through a single full-adder cell.
// The carry lives in a flop between bits; the sum is assembled in a shift
// register and published, together with cout/overflow, on the last bit.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous, active-high reset (clears all state)
//   start    : begin an add; sampled only while idle
//   a, b     : WIDTH-bit operands, captured on accepted start
//   cin      : carry-in, captured on accepted start
//   busy     : high while an add is in progress or completing
//   done     : one-cycle pulse when sum/cout/overflow become valid
//   sum      : WIDTH-bit result (modulo 2^WIDTH)
//   cout     : unsigned carry-out of bit WIDTH-1
//   overflow : two's-complement overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q,  carry_d;
  logic               cmsb_q,   cmsb_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   sum_q,    sum_d;
  logic               cout_q,   cout_d;
  logic               ovf_q,    ovf_d;

  logic fa_s;
  logic fa_c;

  FullAdder u_fa (
    .i1  (a_sr_q[0]),
    .i2  (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        // Carry leaving bit WIDTH-2 is the carry into the MSB; keep it for
        // the signed overflow test on the final bit.
        if (cnt_q == CNT_W'(WIDTH - 2)) begin
          cmsb_d = fa_c;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = sum_sr_d;
          cout_d  = fa_c;
          ovf_d   = fa_c ^ cmsb_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst8, start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  // 16-bit instance
  logic        rst16, start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer addition. Result packed as {ovf, cout, sum}.
  function automatic logic [63:0] ref_add(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic c);
    logic [32:0] full;
    logic [31:0] mask;
    logic [31:0] s;
    logic        co, xs, ys, ss, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, x & mask} + {1'b0, y & mask} + {32'd0, c};
    s    = full[31:0] & mask;
    co   = full[w];
    xs   = x[w-1];
    ys   = y[w-1];
    ss   = s[w-1];
    ov   = (xs == ys) && (ss != xs);
    return {30'd0, ov, co, s};
  endfunction

  logic [63:0] sb8[$];
  logic [63:0] sb16[$];

  // Stimulus side: whenever a start is accepted, record the expected result.
  always @(posedge clk) begin
    if (rst8) sb8.delete();
    else if (start8 && !busy8) sb8.push_back(ref_add(8, {24'd0, a8}, {24'd0, b8}, cin8));
    if (rst16) sb16.delete();
    else if (start16 && !busy16) sb16.push_back(ref_add(16, {16'd0, a16}, {16'd0, b16}, cin16));
  end

  // Monitors: compare whenever the DUT announces a result.
  always @(negedge clk) begin
    logic [63:0] e;
    if (done8) begin
      if (sb8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
      else begin
        e = sb8.pop_front();
        chk("result8", {30'd0, ovf8, cout8, 24'd0, sum8}, e);
      end
    end
    if (done16) begin
      if (sb16.size() == 0) chk("unexpected_done16", 64'd1, 64'd0);
      else begin
        e = sb16.pop_front();
        chk("result16", {30'd0, ovf16, cout16, 16'd0, sum16}, e);
      end
    end
  end

  // Issue one 8-bit add from idle; returns negedges from the start edge to done.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                     input bit scramble, output int lat);
    @(negedge clk);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      if (scramble) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = ~cin8; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic directed8();
    int lat, ndone, didx;
    logic bz10, bz11;
    // reset state
    @(negedge clk);
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_done", {63'd0, done8}, 64'd0);
    chk("rst_outs", {54'd0, ovf8, cout8, sum8}, 64'd0);
    rst8 = 1'b0;
    // test 1: latency and basic result
    op8(8'h5A, 8'h33, 1'b0, 0, lat);
    chk("latency_5A_33", lat, 9);
    // test 2
    op8(8'hFF, 8'h01, 1'b0, 0, lat);
    chk("latency_FF_01", lat, 9);
    op8(8'h80, 8'h80, 1'b0, 0, lat);
    // test 3: operands change after capture
    op8(8'h00, 8'h00, 1'b1, 1, lat);
    chk("latency_scramble", lat, 9);
    chk("hold_after_done", {54'd0, ovf8, cout8, sum8}, {54'd0, 1'b0, 1'b0, 8'h01});
    // test 4: start held high through RUN
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    ndone = 0; didx = 0; bz10 = 1'b1; bz11 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      a8 = 8'hFF;
      if (done8) begin ndone++; didx = i; end
      if (i == 10) bz10 = busy8;
      if (i == 11) bz11 = busy8;
    end
    start8 = 1'b0;
    chk("held_start_done_count", ndone, 1);
    chk("held_start_done_index", didx, 9);
    chk("held_start_idle_gap", {63'd0, bz10}, 64'd0);
    chk("held_start_reaccept", {63'd0, bz11}, 64'd1);
    lat = 0;
    while (!done8 && lat < 40) begin @(negedge clk); lat++; end
    chk("second_add_done", {63'd0, done8}, 64'd1);
    @(negedge clk);
    // test 5: abort in RUN
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) ndone++;
      if (i == 4) rst8 = 1'b1;
    end
    @(negedge clk);
    rst8 = 1'b0;
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_outs", {54'd0, ovf8, cout8, sum8}, 64'd0);
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    op8(8'h7F, 8'h01, 1'b0, 0, lat);
    chk("post_abort_latency", lat, 9);
  endtask

  task automatic random8();
    int ndone = 0, cyc = 0;
    @(negedge clk);
    start8 = 1'b1;
    while (ndone < 200 && cyc < 4000) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (done8) ndone++;
    end
    start8 = 1'b0;
    chk("random8_ops", ndone, 200);
  endtask

  task automatic random16();
    int ndone = 0, cyc = 0;
    repeat (3) @(negedge clk);
    rst16 = 1'b0;
    start16 = 1'b1;
    while (ndone < 200 && cyc < 6000) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (done16) ndone++;
    end
    start16 = 1'b0;
    chk("random16_ops", ndone, 200);
  endtask

  initial begin
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    @(negedge clk);
    fork
      begin directed8(); random8(); end
      random16();
    join
    repeat (5) @(negedge clk);
    chk("sb8_drained", sb8.size(), 0);
    chk("sb16_drained", sb16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
